// File: rtl/param_fifo_pkg.sv
// Shared constants and width helpers for the parameterised FIFO.
// Optional mode: define PARAM_FIFO_FWFT_EN for first-word-fall-through reads.
package param_fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Write/read bus of param_fifo: master is the user, slave is the FIFO.
// Optional mode: PARAM_FIFO_FWFT_EN changes data_out timing only.
interface param_fifo_if
    import param_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

    logic [FIFO_WIDTH-1:0]        data_in;
    logic                         wr_en;
    logic                         rd_en;
    logic [FIFO_WIDTH-1:0]        data_out;
    logic                         wr_ack;
    logic                         overflow;
    logic                         underflow;
    logic                         full;
    logic                         empty;
    logic                         almostfull;
    logic                         almostempty;
    logic [cnt_w(FIFO_DEPTH)-1:0] count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );

endinterface

// File: rtl/param_fifo_mem.sv
// FIFO storage: simple dual-port array, synchronous write, async read.
// Contents are deliberately not reset.
module param_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy count, level flags and access status.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through data_out.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    param_fifo_if.slave bus
);

    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

    if (FIFO_WIDTH < 1 || FIFO_WIDTH > 64) begin : g_bad_width
        $error("param_fifo: FIFO_WIDTH out of range");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 1024) begin : g_bad_depth
        $error("param_fifo: FIFO_DEPTH out of range");
    end
    if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1) begin : g_bad_af
        $error("param_fifo: AF_THRESH out of range");
    end
    if (AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("param_fifo: AE_THRESH out of range");
    end

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_full;
    logic                  w_empty;
    logic [FIFO_WIDTH-1:0] w_head;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // A full FIFO still takes a write when a read frees the slot
    assign w_rd_ok = bus.rd_en && !w_empty;
    assign w_wr_ok = bus.wr_en && (!w_full || w_rd_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_wr_ack <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wptr <= inc(r_wptr);
            if (w_rd_ok) r_rptr <= inc(r_rptr);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_ack <= w_wr_ok;
            r_ovf    <= bus.wr_en && !w_wr_ok;
            r_udf    <= bus.rd_en && !w_rd_ok;
        end
    end

    param_fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .PW    (PW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

`ifdef PARAM_FIFO_FWFT_EN
    assign bus.data_out = w_empty ? '0 : w_head;
`else
    logic [FIFO_WIDTH-1:0] r_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (w_rd_ok) begin
            r_dout <= w_head;
        end
    end

    assign bus.data_out = r_dout;
`endif

    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count >= AF_C) && !w_full;
    assign bus.almostempty = (r_count <= AE_C) && !w_empty;
    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_udf;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (depth 8 and depth 5 instances).
// Works in both builds; PARAM_FIFO_FWFT_EN selects the data_out model.
module tb_param_fifo;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    param_fifo_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) bus8 ();
    param_fifo_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) bus5 ();

    param_fifo #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (8),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    param_fifo #(
        .FIFO_WIDTH (16),
        .FIFO_DEPTH (5)
    ) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] din;
        int          cnt;
        bit          full;
        bit          empty;
        bit          af;
        bit          ae;
        bit          ack;
        bit          ovf;
        bit          udf;
        logic [15:0] dstd;
        logic [15:0] dfw;
    } row_t;

    row_t        tbl[18];
    logic [15:0] q[$];
    logic [15:0] exp_dout;

    function automatic row_t mk(
        bit wr, bit rd, logic [15:0] din, int cnt,
        bit full, bit empty, bit af, bit ae,
        bit ack, bit ovf, bit udf,
        logic [15:0] dstd, logic [15:0] dfw
    );
        row_t r;
        r.wr = wr; r.rd = rd; r.din = din; r.cnt = cnt;
        r.full = full; r.empty = empty; r.af = af; r.ae = ae;
        r.ack = ack; r.ovf = ovf; r.udf = udf;
        r.dstd = dstd; r.dfw = dfw;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // One clock of the depth-8 FIFO, checked against a queue model
    task automatic step(input bit wr, input bit rd, input logic [15:0] din);
        bit rd_ok;
        bit wr_ok;
        int n;
        bus8.wr_en   = wr;
        bus8.rd_en   = rd;
        bus8.data_in = din;
        rd_ok = rd && (q.size() > 0);
        wr_ok = wr && (q.size() < 8 || rd_ok);
        if (rd_ok) begin
`ifdef PARAM_FIFO_FWFT_EN
            void'(q.pop_front());
`else
            exp_dout = q.pop_front();
`endif
        end
        if (wr_ok) q.push_back(din);
        @(posedge clk);
        #1;
        bus8.wr_en = 1'b0;
        bus8.rd_en = 1'b0;
        n = q.size();
`ifdef PARAM_FIFO_FWFT_EN
        exp_dout = (n > 0) ? q[0] : 16'h0;
`endif
        chk("count", bus8.count, n);
        chk("full", bus8.full, n == 8);
        chk("empty", bus8.empty, n == 0);
        chk("almostfull", bus8.almostfull, n >= 6 && n < 8);
        chk("almostempty", bus8.almostempty, n >= 1 && n <= 2);
        chk("wr_ack", bus8.wr_ack, wr_ok);
        chk("overflow", bus8.overflow, wr && !wr_ok);
        chk("underflow", bus8.underflow, rd && !rd_ok);
        chk("data_out", bus8.data_out, exp_dout);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        exp_dout = 16'h0;

        tbl[0]  = mk(1, 0, 16'd1, 1, 0, 0, 0, 1, 1, 0, 0, 16'd0, 16'd1);
        tbl[1]  = mk(1, 0, 16'd2, 2, 0, 0, 0, 1, 1, 0, 0, 16'd0, 16'd1);
        tbl[2]  = mk(1, 0, 16'd3, 3, 0, 0, 0, 0, 1, 0, 0, 16'd0, 16'd1);
        tbl[3]  = mk(1, 0, 16'd4, 4, 0, 0, 0, 0, 1, 0, 0, 16'd0, 16'd1);
        tbl[4]  = mk(1, 0, 16'd5, 5, 0, 0, 0, 0, 1, 0, 0, 16'd0, 16'd1);
        tbl[5]  = mk(1, 0, 16'd6, 6, 0, 0, 1, 0, 1, 0, 0, 16'd0, 16'd1);
        tbl[6]  = mk(1, 0, 16'd7, 7, 0, 0, 1, 0, 1, 0, 0, 16'd0, 16'd1);
        tbl[7]  = mk(1, 0, 16'd8, 8, 1, 0, 0, 0, 1, 0, 0, 16'd0, 16'd1);
        tbl[8]  = mk(1, 0, 16'd9, 8, 1, 0, 0, 0, 0, 1, 0, 16'd0, 16'd1);
        tbl[9]  = mk(0, 1, 16'd0, 7, 0, 0, 1, 0, 0, 0, 0, 16'd1, 16'd2);
        tbl[10] = mk(0, 1, 16'd0, 6, 0, 0, 1, 0, 0, 0, 0, 16'd2, 16'd3);
        tbl[11] = mk(0, 1, 16'd0, 5, 0, 0, 0, 0, 0, 0, 0, 16'd3, 16'd4);
        tbl[12] = mk(0, 1, 16'd0, 4, 0, 0, 0, 0, 0, 0, 0, 16'd4, 16'd5);
        tbl[13] = mk(0, 1, 16'd0, 3, 0, 0, 0, 0, 0, 0, 0, 16'd5, 16'd6);
        tbl[14] = mk(0, 1, 16'd0, 2, 0, 0, 0, 1, 0, 0, 0, 16'd6, 16'd7);
        tbl[15] = mk(0, 1, 16'd0, 1, 0, 0, 0, 1, 0, 0, 0, 16'd7, 16'd8);
        tbl[16] = mk(0, 1, 16'd0, 0, 0, 1, 0, 0, 0, 0, 0, 16'd8, 16'd0);
        tbl[17] = mk(0, 1, 16'd0, 0, 0, 1, 0, 0, 0, 0, 1, 16'd8, 16'd0);

        rst_n = 1'b0;
        bus8.wr_en = 1'b0; bus8.rd_en = 1'b0; bus8.data_in = '0;
        bus5.wr_en = 1'b0; bus5.rd_en = 1'b0; bus5.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", bus8.count, 0);
        chk("rst empty", bus8.empty, 1);
        chk("rst full", bus8.full, 0);
        chk("rst almostfull", bus8.almostfull, 0);
        chk("rst almostempty", bus8.almostempty, 0);
        chk("rst data_out", bus8.data_out, 0);
        chk("rst flags", {bus8.wr_ack, bus8.overflow, bus8.underflow}, 0);
        rst_n = 1'b1;

        // Fill/drain with literal flag expectations
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk($sformatf("tbl%0d count", i), bus8.count, tbl[i].cnt);
            chk($sformatf("tbl%0d flags", i),
                {bus8.full, bus8.empty, bus8.almostfull, bus8.almostempty},
                {tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae});
            chk($sformatf("tbl%0d status", i),
                {bus8.wr_ack, bus8.overflow, bus8.underflow},
                {tbl[i].ack, tbl[i].ovf, tbl[i].udf});
`ifdef PARAM_FIFO_FWFT_EN
            chk($sformatf("tbl%0d data", i), bus8.data_out, tbl[i].dfw);
`else
            chk($sformatf("tbl%0d data", i), bus8.data_out, tbl[i].dstd);
`endif
        end

        // Simultaneous access at full
        for (int i = 0; i < 8; i++) step(1, 0, 16'h0010 + 16'(i));
        step(1, 1, 16'hBEEF);
        chk("full rw ack", bus8.wr_ack, 1);
        chk("full rw count", bus8.count, 8);
`ifdef PARAM_FIFO_FWFT_EN
        chk("full rw data", bus8.data_out, 16'h0011);
`else
        chk("full rw data", bus8.data_out, 16'h0010);
`endif
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0);
`ifndef PARAM_FIFO_FWFT_EN
        chk("beef last", bus8.data_out, 16'hBEEF);
`endif

        // Simultaneous access at empty
        step(1, 1, 16'h55AA);
        chk("empty rw udf", bus8.underflow, 1);
        chk("empty rw ack", bus8.wr_ack, 1);
        chk("empty rw count", bus8.count, 1);
        step(0, 1, 16'h0);

        // Wrap-around with interleaved pairs
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 16'h0100 + 16'(i));
            chk("wrap count", bus8.count <= 2, 1);
            step(0, 1, 16'h0);
        end

        // Reset mid-operation at count 5
        for (int i = 0; i < 5; i++) step(1, 0, 16'h0A00 + 16'(i));
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid rst count", bus8.count, 0);
        chk("mid rst empty", bus8.empty, 1);
        chk("mid rst data_out", bus8.data_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        exp_dout = 16'h0;
        step(1, 0, 16'h1234);
        step(0, 1, 16'h0);
`ifndef PARAM_FIFO_FWFT_EN
        chk("post rst read", bus8.data_out, 16'h1234);
`endif

        // Randomised traffic, write-heavy then read-heavy
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 300) ? 65 : 35;
            step($urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 16'($urandom));
        end

        // Non-power-of-two depth fill/drain on the depth-5 instance
        for (int i = 1; i <= 6; i++) begin
            bus5.wr_en   = 1'b1;
            bus5.data_in = 16'(i);
            @(posedge clk);
            #1;
            chk("d5 wr_ack", bus5.wr_ack, i <= 5);
            chk("d5 overflow", bus5.overflow, i > 5);
            chk("d5 count", bus5.count, (i > 5) ? 5 : i);
            if (i == 1) begin
                bus5.wr_en = 1'b0;
`ifdef PARAM_FIFO_FWFT_EN
                chk("d5 first fwft", bus5.data_out, 16'h0001);
`else
                chk("d5 first std", bus5.data_out, 16'h0000);
`endif
            end
        end
        bus5.wr_en = 1'b0;
        chk("d5 full", bus5.full, 1);
        for (int r = 1; r <= 6; r++) begin
            bus5.rd_en = 1'b1;
            @(posedge clk);
            #1;
            chk("d5 underflow", bus5.underflow, r > 5);
            chk("d5 rd count", bus5.count, (r > 5) ? 0 : 5 - r);
`ifdef PARAM_FIFO_FWFT_EN
            chk("d5 data", bus5.data_out, (r < 5) ? 16'(r + 1) : 16'h0);
`else
            chk("d5 data", bus5.data_out, (r > 5) ? 16'd5 : 16'(r));
`endif
        end
        bus5.rd_en = 1'b0;
        chk("d5 empty", bus5.empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
